tdm_demux_1_16: RTL and testbench

Time-division demultiplexer, 1 serial lane to 16 channels. It receives one sample per enabled cycle, framed by a slot-0 sync strobe. Each sample is steered into its channel slot. A complete 16-slot frame is published as one registered parallel word. It sits at the receive end of a TDM link whose transmit end serialises 16 channel inputs through a select-driven 16:1 mux.

---
 rtl/tdm_demux_pkg.sv | 19 +
 rtl/tdm_slot_counter.sv | 33 +++
 rtl/tdm_demux_1_16.sv | 137 +++++++++++++
 tb/tb_tdm_demux_1_16.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg: shared types and default sizing for the 1:16 TDM demultiplexer.
// Optional feature macro used by the top: TDM_DEMUX_ERR_CNT_EN (saturating error counter).
package tdm_demux_pkg;

  // Framing state: waiting for a slot-0 sync, or filling a frame.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Default frame geometry: 16 one-bit slots.
  localparam int NUM_CHANNELS_DEF = 16;
  localparam int SEL_WIDTH_DEF    = 4;
  localparam int DATA_WIDTH_DEF   = 1;

  // Error counter saturates here instead of wrapping.
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: slot index for the framing FSM.
// Priority: clear > load-1 > increment (wrapping after the last slot) > hold.
// 'last' flags that the current index is the final slot of a frame.
module tdm_slot_counter
  import tdm_demux_pkg::*;
#(
  parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
  parameter int SEL_WIDTH    = SEL_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 load_one,
  input  logic                 inc,
  output logic [SEL_WIDTH-1:0] count,
  output logic                 last
);

  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_CHANNELS - 1);
  localparam logic [SEL_WIDTH-1:0] ONE      = SEL_WIDTH'(1);

  // Last-slot decode drives both the wrap and frame publication upstream.
  always_comb last = (count == LAST_IDX);

  // Slot index register; a load of 1 means slot 0 was just filled by a sync sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           count <= '0;
    else if (clr)      count <= '0;
    else if (load_one) count <= ONE;
    else if (inc)      count <= last ? '0 : count + ONE;
  end

endmodule

// File: rtl/tdm_demux_1_16.sv
// tdm_demux_1_16: 1-lane to NUM_CHANNELS-slot TDM demultiplexer.
// Samples are qualified by Enable_In and framed by Frame_Sync_In on slot 0.
// Slots accumulate in a shadow register; a complete frame is published to
// Channel_Data_Out one clock after its last slot, with a Frame_Valid_Out pulse.
// Framing violations give a registered Sync_Error_Out pulse.
// Optional: define TDM_DEMUX_ERR_CNT_EN to add the saturating Error_Count_Out port.
module tdm_demux_1_16
  import tdm_demux_pkg::*;
#(
  parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
  parameter int SEL_WIDTH    = SEL_WIDTH_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF
) (
  input  logic                               Clk_In,
  input  logic                               Reset_In,
  input  logic                               Enable_In,
  input  logic                               Frame_Sync_In,
  input  logic [DATA_WIDTH-1:0]              Data_In,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] Channel_Data_Out,
  output logic                               Frame_Valid_Out,
  output logic [SEL_WIDTH-1:0]               Slot_Select_Out,
  output logic                               Sync_Error_Out
`ifdef TDM_DEMUX_ERR_CNT_EN
  ,
  output logic [7:0]                         Error_Count_Out
`endif
);

  state_t                                    state, state_nxt;
  logic [SEL_WIDTH-1:0]                      slot_cnt, wr_idx;
  logic                                      slot_last;
  logic                                      cnt_clr, cnt_load, cnt_inc;
  logic                                      wr_en, pub_nxt, err_nxt;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]   shadow, merged;

  tdm_slot_counter #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .SEL_WIDTH    (SEL_WIDTH)
  ) u_slot_cnt (
    .clk      (Clk_In),
    .rst      (Reset_In),
    .clr      (cnt_clr),
    .load_one (cnt_load),
    .inc      (cnt_inc),
    .count    (slot_cnt),
    .last     (slot_last)
  );

  // A sync sample always lands in slot 0 (fresh frame or resync); otherwise the counter picks the slot.
  always_comb wr_idx = Frame_Sync_In ? '0 : slot_cnt;

  // State register.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) state <= IDLE;
    else          state <= state_nxt;
  end

  // Framing decisions; nothing moves on cycles without Enable_In.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    wr_en     = 1'b0;
    pub_nxt   = 1'b0;
    err_nxt   = 1'b0;
    if (Enable_In) begin
      case (state)
        IDLE: begin
          if (Frame_Sync_In) begin
            wr_en     = 1'b1;
            cnt_load  = 1'b1;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (Frame_Sync_In && (slot_cnt != '0)) begin
            // Early sync: drop the partial frame and restart at slot 0.
            err_nxt  = 1'b1;
            wr_en    = 1'b1;
            cnt_load = 1'b1;
          end else if (!Frame_Sync_In && (slot_cnt == '0)) begin
            // Expected a sync at slot 0: lose lock and wait for the next one.
            err_nxt   = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = IDLE;
          end else begin
            wr_en   = 1'b1;
            cnt_inc = 1'b1;
            pub_nxt = slot_last;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Shadow contents including this cycle's sample, so the last slot can be published without a bubble.
  always_comb begin
    merged = shadow;
    if (wr_en) merged[wr_idx] = Data_In;
  end

  // Shadow register; stale slots from a dropped frame are simply overwritten later.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In)   shadow <= '0;
    else if (wr_en) shadow <= merged;
  end

  // Published frame and the two pulse outputs; only complete frames ever load Channel_Data_Out.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      Channel_Data_Out <= '0;
      Frame_Valid_Out  <= 1'b0;
      Sync_Error_Out   <= 1'b0;
    end else begin
      Frame_Valid_Out <= pub_nxt;
      Sync_Error_Out  <= err_nxt;
      if (pub_nxt) Channel_Data_Out <= merged;
    end
  end

  always_comb Slot_Select_Out = slot_cnt;

`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [7:0] err_cnt;

  // Saturating count of framing errors, cleared only by reset.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In)                               err_cnt <= '0;
    else if (err_nxt && err_cnt != ERR_CNT_MAX) err_cnt <= err_cnt + 8'd1;
  end

  always_comb Error_Count_Out = err_cnt;
`endif

endmodule

// File: tb/tb_tdm_demux_1_16.sv
// tb_tdm_demux_1_16: table-driven frames plus hand sequences for framing errors and async reset.
// Published frames are tracked with a scoreboard queue filled when the last slot is driven.
module tb_tdm_demux_1_16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sync = 1'b0;
  logic [0:0]  din = 1'b0;
  logic [15:0] ch_data;
  logic        fvalid;
  logic [3:0]  slot_sel;
  logic        serr;
`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  tdm_demux_1_16 dut (
    .Clk_In           (clk),
    .Reset_In         (rst),
    .Enable_In        (en),
    .Frame_Sync_In    (sync),
    .Data_In          (din),
    .Channel_Data_Out (ch_data),
    .Frame_Valid_Out  (fvalid),
    .Slot_Select_Out  (slot_sel),
    .Sync_Error_Out   (serr)
`ifdef TDM_DEMUX_ERR_CNT_EN
    ,
    .Error_Count_Out  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] sb_q[$];

  typedef struct {
    logic [15:0] data;
    int          stall_at;
    int          stall_len;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  // Drive one cycle of stimulus, then check the pulse outputs and the scoreboard just after the edge.
  task automatic step(input logic e, input logic s, input logic d,
                      input logic want_err, input logic push, input logic [15:0] pv);
    logic [15:0] exp_frame;
    en = e; sync = s; din = d;
    if (push) sb_q.push_back(pv);
    @(posedge clk); #1;
    chk("sync_error", {31'd0, serr}, {31'd0, want_err});
    if (sb_q.size() > 0) begin
      exp_frame = sb_q.pop_front();
      chk("frame_valid", {31'd0, fvalid}, 32'd1);
      chk("frame_data", {16'd0, ch_data}, {16'd0, exp_frame});
    end else begin
      chk("frame_valid", {31'd0, fvalid}, 32'd0);
    end
  endtask

  // One clean frame, optionally with Enable_In low for stall_len cycles before slot stall_at.
  task automatic send_frame(input logic [15:0] data, input int stall_at, input int stall_len);
    for (int k = 0; k < 16; k++) begin
      if (k == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
          chk("stall_slot_hold", {28'd0, slot_sel}, k);
        end
      end
      step(1'b1, k == 0, data[k], 1'b0, k == 15, data);
    end
    chk("frame_out", {16'd0, ch_data}, {16'd0, data});
    chk("slot_wrap", {28'd0, slot_sel}, 32'd0);
  endtask

  logic [15:0] pat;

  initial begin
    vecs[0] = '{16'hA5C3, -1, 0};
    vecs[1] = '{16'hA5C3,  8, 3};
    vecs[2] = '{16'h0000, -1, 0};
    vecs[3] = '{16'hFFFF,  1, 2};
    vecs[4] = '{16'h8001, 15, 1};
    vecs[5] = '{16'h3C96, -1, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data",  {16'd0, ch_data}, 32'd0);
    chk("rst_valid", {31'd0, fvalid}, 32'd0);
    chk("rst_slot",  {28'd0, slot_sel}, 32'd0);
    chk("rst_err",   {31'd0, serr}, 32'd0);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    // Sync-less samples in IDLE are ignored without error.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("idle_slot", {28'd0, slot_sel}, 32'd0);

    // Back-to-back clean frames, some with stalls
    foreach (vecs[i]) send_frame(vecs[i].data, vecs[i].stall_at, vecs[i].stall_len);

    // Early sync at slot 9; the resync sample starts a 16'h1234 frame
    pat = 16'hBEEF;
    for (int k = 0; k < 9; k++) step(1'b1, k == 0, pat[k], 1'b0, 1'b0, 16'h0);
    pat = 16'h1234;
    step(1'b1, 1'b1, pat[0], 1'b1, 1'b0, 16'h0);
    chk("early_sync_slot", {28'd0, slot_sel}, 32'd1);
    chk("early_sync_hold", {16'd0, ch_data}, 32'h3C96);
    for (int k = 1; k < 16; k++) step(1'b1, 1'b0, pat[k], 1'b0, k == 15, pat);
    chk("resync_frame", {16'd0, ch_data}, 32'h1234);

    // Missing sync after a valid frame
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("miss_sync_slot", {28'd0, slot_sel}, 32'd0);
    chk("miss_sync_hold", {16'd0, ch_data}, 32'h1234);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("idle_no_err_slot", {28'd0, slot_sel}, 32'd0);

    // Async reset mid-frame, between clock edges
    pat = 16'h7777;
    for (int k = 0; k < 5; k++) step(1'b1, k == 0, pat[k], 1'b0, 1'b0, 16'h0);
    chk("pre_reset_slot", {28'd0, slot_sel}, 32'd5);
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_data",  {16'd0, ch_data}, 32'd0);
    chk("async_rst_slot",  {28'd0, slot_sel}, 32'd0);
    chk("async_rst_valid", {31'd0, fvalid}, 32'd0);
    chk("async_rst_err",   {31'd0, serr}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_frame(16'hFFFF, -1, 0);

`ifdef TDM_DEMUX_ERR_CNT_EN
    // 301 consecutive sync samples: the first starts a frame, the rest are early syncs
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int k = 0; k < 300; k++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("err_cnt_sat", {24'd0, err_cnt}, 32'h0000_00FF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
